// File: rtl/mux_rr_sel_ctrl_if.sv
// Handshake bundle between two burst sources, the select controller
// and the downstream consumer of the 2-to-1 mux.
interface mux_rr_sel_ctrl_if #(
    parameter int CNT_W = 5
) ();
    logic             req_0;
    logic             last_0;
    logic             req_1;
    logic             last_1;
    logic             out_ready;
    logic             sel;
    logic             gnt_0;
    logic             gnt_1;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        output req_0, last_0, req_1, last_1, out_ready,
        input  sel, gnt_0, gnt_1, out_valid, out_last,
        input  busy, beat_cnt
    );

    modport slave (
        input  req_0, last_0, req_1, last_1, out_ready,
        output sel, gnt_0, gnt_1, out_valid, out_last,
        output busy, beat_cnt
    );
endinterface

// File: rtl/mux_rr_sel_ctrl.sv
// Round-robin select controller for a 2-to-1 burst mux.
// Select is registered and locked for the whole burst.
module mux_rr_sel_ctrl #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    mux_rr_sel_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             sel_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_g0, in_g1;
    logic gnt_0, gnt_1;
    logic cur_req, cur_last, oth_req;
    logic xfer, eob;

    assign in_g0 = (state_q == GRANT0);
    assign in_g1 = (state_q == GRANT1);

    assign gnt_0 = in_g0 & bus.req_0 & bus.out_ready;
    assign gnt_1 = in_g1 & bus.req_1 & bus.out_ready;

    assign cur_req  = in_g1 ? bus.req_1  : bus.req_0;
    assign cur_last = in_g1 ? bus.last_1 : bus.last_0;
    assign oth_req  = in_g1 ? bus.req_0  : bus.req_1;

    assign xfer = gnt_0 | gnt_1;
    assign eob  = xfer & (cur_last | (cnt_q == LAST_BEAT));

    assign bus.sel       = sel_q;
    assign bus.gnt_0     = gnt_0;
    assign bus.gnt_1     = gnt_1;
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (in_g0 | in_g1) & cur_req;
    assign bus.out_last  = (in_g0 | in_g1) & cur_req & cur_last;
    assign bus.beat_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    bus.req_0 & bus.req_1:
                        state_d = prio_q ? GRANT1 : GRANT0;
                    bus.req_0 & ~bus.req_1:
                        state_d = GRANT0;
                    ~bus.req_0 & bus.req_1:
                        state_d = GRANT1;
                    default:
                        state_d = IDLE;
                endcase
            end
            GRANT0, GRANT1: begin
                if (eob) begin
                    // hand straight over to the waiting channel, no bubble
                    prio_d = ~in_g1;
                    cnt_d  = '0;
                    if (oth_req)
                        state_d = in_g1 ? GRANT0 : GRANT1;
                    else if (cur_req)
                        state_d = state_q;
                    else
                        state_d = IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= (state_d == GRANT1);
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mux_rr_sel_ctrl.sv
// Randomized scoreboard bench for mux_rr_sel_ctrl against
// a transaction-level model of owner, turn and beat count.
module tb_mux_rr_sel_ctrl;
    localparam int MAXB = 4;
    localparam int CW   = 5;

    logic clk = 1'b0;
    logic reset;

    mux_rr_sel_ctrl_if #(.CNT_W(CW)) bus ();

    mux_rr_sel_ctrl #(.MAX_BEATS(MAXB), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int gnt0;
        int gnt1;
        int ov;
        int ol;
        int busy;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("sel",       int'(bus.sel),       e.sel);
            check("gnt_0",     int'(bus.gnt_0),     e.gnt0);
            check("gnt_1",     int'(bus.gnt_1),     e.gnt1);
            check("out_valid", int'(bus.out_valid), e.ov);
            check("out_last",  int'(bus.out_last),  e.ol);
            check("busy",      int'(bus.busy),      e.busy);
            check("beat_cnt",  int'(bus.beat_cnt),  e.cnt);
        end
    end

    // reference: -1 = nobody owns the mux, else owning channel
    int owner = -1;
    int turn  = 0;
    int beats = 0;

    // source-side burst generators
    bit have [2];
    bit lst  [2];
    int rem  [2];

    initial begin
        int   rdy_pct, req_pct;
        bit   rq [2];
        bit   g  [2];
        bit   rdy, rst;
        exp_t e;

        have = '{0, 0};
        lst  = '{0, 0};
        rem  = '{0, 0};

        reset         = 1'b1;
        bus.req_0     = 1'b0;
        bus.last_0    = 1'b0;
        bus.req_1     = 1'b0;
        bus.last_1    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            case ((cyc / 500) % 3)
                0:       begin rdy_pct = 100; req_pct = 90; end
                1:       begin rdy_pct = 70;  req_pct = 60; end
                default: begin rdy_pct = 30;  req_pct = 80; end
            endcase

            for (int n = 0; n < 2; n++) begin
                if (!have[n] && ($urandom % 100) < req_pct) begin
                    if (rem[n] == 0) rem[n] = $urandom_range(1, 7);
                    have[n] = 1'b1;
                    lst[n]  = (rem[n] == 1);
                end
                rq[n] = have[n];
            end
            rdy = (($urandom % 100) < rdy_pct);
            rst = (cyc < 3) || (($urandom % 60) == 0);

            reset         = rst;
            bus.req_0     = rq[0];
            bus.last_0    = rq[0] & lst[0];
            bus.req_1     = rq[1];
            bus.last_1    = rq[1] & lst[1];
            bus.out_ready = rdy;

            for (int n = 0; n < 2; n++)
                g[n] = (owner == n) && rq[n] && rdy;

            e.sel  = (owner == 1);
            e.gnt0 = g[0];
            e.gnt1 = g[1];
            e.ov   = (owner >= 0) && rq[owner];
            e.ol   = (owner >= 0) && rq[owner] && lst[owner];
            e.busy = (owner >= 0);
            e.cnt  = beats;
            q.push_back(e);

            if (rst) begin
                owner = -1;
                turn  = 0;
                beats = 0;
            end else if (owner < 0) begin
                if (rq[0] && rq[1]) owner = turn;
                else if (rq[0])     owner = 0;
                else if (rq[1])     owner = 1;
            end else if (g[owner]) begin
                if (lst[owner] || beats + 1 == MAXB) begin
                    turn  = 1 - owner;
                    beats = 0;
                    if (rq[1 - owner])  owner = 1 - owner;
                    else if (rq[owner]) owner = owner;
                    else                owner = -1;
                end else begin
                    beats++;
                end
            end

            for (int n = 0; n < 2; n++)
                if (g[n]) begin
                    have[n] = 1'b0;
                    rem[n]--;
                end
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        check("drain", q.size(), 0);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
